// File: rtl/cam_pixel_capture.sv
// Captures RGB444 pixels (two bytes each) from a DVP-style camera and emits
// frame-buffer writes, with line/frame geometry checking and sticky error flags.
module cam_pixel_capture #(
  parameter int H_PIXELS = 640,
  parameter int V_LINES  = 480,
  parameter int ADDR_W   = 19
) (
  input  logic              cam_clk,
  input  logic              rstn,
  input  logic              enable,
  input  logic              err_clr,
  input  logic              cam_vsync,
  input  logic              cam_href,
  input  logic [7:0]        cam_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [11:0]       wr_data,
  output logic              frame_done,
  output logic              busy,
  output logic              line_err,
  output logic              frame_err,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT_VS = 2'd1, ACTIVE = 2'd2} state_t;

  localparam int              PIX_W     = $clog2(H_PIXELS + 1) + 1;
  localparam logic [ADDR_W:0] TOTAL     = (ADDR_W + 1)'(H_PIXELS * V_LINES);
  localparam logic [9:0]      LINES_EXP = 10'(V_LINES);
  localparam logic [PIX_W-1:0] PIX_EXP  = PIX_W'(H_PIXELS);

  state_t            state, state_nxt;
  logic              vs1, hr1, vs2, hr2;
  logic [7:0]        d1;
  logic              phase;
  logic [3:0]        r_lat;
  logic              pix_vld;
  logic [11:0]       pix;
  logic [PIX_W-1:0]  pix_cnt;
  logic [9:0]        line_cnt, line_cnt_nxt;
  logic              busy_d, frame_done_d;

  logic vs_fall, vs_rise, hr_rise, hr_fall;
  logic active, start, frame_end, line_end, line_bad, frame_bad, pix_form, overflow;

  // Stage s1 plus one delayed copy of the sync lines for edge detection.
  always_ff @(posedge cam_clk or negedge rstn) begin
    if (!rstn) begin
      vs1 <= 1'b0;
      hr1 <= 1'b0;
      d1  <= '0;
      vs2 <= 1'b0;
      hr2 <= 1'b0;
    end else begin
      vs1 <= cam_vsync;
      hr1 <= cam_href;
      d1  <= cam_data;
      vs2 <= vs1;
      hr2 <= hr1;
    end
  end

  assign vs_fall   = vs2 & ~vs1;
  assign vs_rise   = ~vs2 & vs1;
  assign hr_rise   = hr1 & ~hr2;
  assign hr_fall   = ~hr1 & hr2;
  assign active    = (state == ACTIVE);
  assign start     = (state == WAIT_VS) && (state_nxt == ACTIVE);
  assign frame_end = active & vs_rise;
  assign line_end  = active & hr_fall;
  assign line_bad  = line_end & ((pix_cnt != PIX_EXP) | phase);
  assign pix_form  = active & hr1 & phase;
  assign overflow  = pix_vld & ({1'b0, wr_addr} >= TOTAL);

  // A line ending together with the frame is counted before the frame check.
  assign line_cnt_nxt = (line_end && line_cnt != 10'd1023) ? line_cnt + 10'd1 : line_cnt;
  assign frame_bad    = frame_end & (line_cnt_nxt != LINES_EXP);

  always_ff @(posedge cam_clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (enable) state_nxt = WAIT_VS;
      WAIT_VS: begin
        if (!enable)      state_nxt = IDLE;
        else if (vs_fall) state_nxt = ACTIVE;
      end
      ACTIVE:  if (vs_rise) state_nxt = enable ? WAIT_VS : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy_d       = (state_nxt == ACTIVE);
    frame_done_d = frame_end;
  end

  assign dbg_state = state;

  // Byte assembly: phase 0 holds red, phase 1 completes the pixel.
  always_ff @(posedge cam_clk or negedge rstn) begin
    if (!rstn) begin
      phase    <= 1'b0;
      r_lat    <= '0;
      pix_vld  <= 1'b0;
      pix      <= '0;
      pix_cnt  <= '0;
      line_cnt <= '0;
    end else begin
      if (!hr1)        phase <= 1'b0;
      else if (active) phase <= ~phase;
      if (active && hr1 && !phase) r_lat <= d1[3:0];
      pix_vld <= pix_form;
      if (pix_form) pix <= {r_lat, d1};
      if (start)                                  pix_cnt <= '0;
      else if (active && hr_rise)                 pix_cnt <= '0;
      else if (pix_form && pix_cnt != '1)         pix_cnt <= pix_cnt + PIX_W'(1);
      if (start) line_cnt <= '0;
      else       line_cnt <= line_cnt_nxt;
    end
  end

  // wr_en is a pure strobe (no back-pressure): wr_addr/wr_data are valid only
  // in the cycle wr_en is high, and wr_addr advances the following cycle.
  always_ff @(posedge cam_clk or negedge rstn) begin
    if (!rstn) begin
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
      line_err   <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      wr_en <= pix_vld & ~overflow;
      if (pix_vld && !overflow) wr_data <= pix;
      if (start)      wr_addr <= '0;
      else if (wr_en) wr_addr <= wr_addr + ADDR_W'(1);
      frame_done <= frame_done_d;
      busy       <= busy_d;
      if (line_bad)     line_err <= 1'b1;
      else if (err_clr) line_err <= 1'b0;
      if (frame_bad || overflow) frame_err <= 1'b1;
      else if (err_clr)          frame_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cam_pixel_capture.sv
// Directed bench for cam_pixel_capture with a 4x2 frame geometry; expected
// writes go into a queue that a negedge monitor pops whenever wr_en is seen.
module tb_cam_pixel_capture;

  localparam int H  = 4;
  localparam int V  = 2;
  localparam int AW = 19;

  logic          cam_clk, rstn, enable, err_clr, cam_vsync, cam_href;
  logic [7:0]    cam_data;
  logic          wr_en, frame_done, busy, line_err, frame_err;
  logic [AW-1:0] wr_addr;
  logic [11:0]   wr_data;
  logic [1:0]    dbg_state;

  logic [AW+11:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int fd_cnt = 0;
  int exp_addr = 0;
  bit cap = 0;

  cam_pixel_capture #(.H_PIXELS(H), .V_LINES(V), .ADDR_W(AW)) dut (
    .cam_clk(cam_clk), .rstn(rstn), .enable(enable), .err_clr(err_clr),
    .cam_vsync(cam_vsync), .cam_href(cam_href), .cam_data(cam_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .frame_done(frame_done), .busy(busy), .line_err(line_err),
    .frame_err(frame_err), .dbg_state(dbg_state)
  );

  initial begin
    cam_clk = 1'b0;
    forever #5 cam_clk = ~cam_clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops one expected write per wr_en and counts frame_done pulses.
  always @(negedge cam_clk) begin
    if (rstn) begin
      if (wr_en) begin
        if (exp_q.size() == 0) begin
          check("unexpected_write", {13'd0, wr_addr}, 32'hFFFF_FFFF);
        end else begin
          logic [AW+11:0] e;
          e = exp_q.pop_front();
          check("wr_addr", {13'd0, wr_addr}, {13'd0, e[AW+11:12]});
          check("wr_data", {20'd0, wr_data}, {20'd0, e[11:0]});
        end
      end
      if (frame_done) fd_cnt++;
    end
  end

  task automatic tick();
    @(posedge cam_clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic frame_begin();
    cam_vsync = 1'b0;
    if (cap) exp_addr = 0;
    idle(3);
  endtask

  task automatic frame_end();
    cam_vsync = 1'b1;
    idle(4);
  endtask

  task automatic send_line(input int n, input logic [7:0] b0, input logic [7:0] b1,
                           input bit clr_end);
    logic [AW-1:0] a;
    for (int i = 0; i < n; i++) begin
      cam_href = 1'b1;
      cam_data = (i % 2 == 0) ? b0 : b1;
      if ((i % 2 == 1) && cap) begin
        if (exp_addr < H * V) begin
          a = exp_addr[AW-1:0];
          exp_q.push_back({a, b0[3:0], b1});
        end
        exp_addr++;
      end
      tick();
    end
    cam_href = 1'b0;
    cam_data = 8'h00;
    tick();
    if (clr_end) begin
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      idle(2);
    end else begin
      idle(3);
    end
  endtask

  task automatic clear_errors();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
  endtask

  initial begin
    rstn = 1'b0; enable = 1'b0; err_clr = 1'b0;
    cam_vsync = 1'b1; cam_href = 1'b0; cam_data = 8'h00;
    idle(3);
    check("rst_wr_en", {31'd0, wr_en}, 32'd0);
    check("rst_wr_addr", {13'd0, wr_addr}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_frame_done", {31'd0, frame_done}, 32'd0);
    check("rst_errs", {30'd0, line_err, frame_err}, 32'd0);
    check("rst_state", {30'd0, dbg_state}, 32'd0);
    rstn = 1'b1;
    idle(2);

    // Basic frame: 2 lines of 0x0A,0x5C -> 0xA5C at addr 0..7
    enable = 1'b1;
    idle(3);
    check("wait_vs_state", {30'd0, dbg_state}, 32'd1);
    cap = 1;
    frame_begin();
    check("busy_active", {31'd0, busy}, 32'd1);
    send_line(8, 8'h0A, 8'h5C, 1'b0);
    send_line(8, 8'h0A, 8'h5C, 1'b0);
    frame_end();
    check("f1_frame_done", fd_cnt, 32'd1);
    check("f1_errs", {30'd0, line_err, frame_err}, 32'd0);
    check("f1_state", {30'd0, dbg_state}, 32'd1);
    check("f1_busy", {31'd0, busy}, 32'd0);

    // Varied data; upper nibble of byte0 must be ignored
    frame_begin();
    send_line(8, 8'h03, 8'h9F, 1'b0);
    send_line(8, 8'hF7, 8'h10, 1'b0);
    frame_end();
    check("f2_frame_done", fd_cnt, 32'd2);
    check("f2_errs", {30'd0, line_err, frame_err}, 32'd0);

    // Odd-length line: line_err only
    frame_begin();
    send_line(7, 8'h0A, 8'h5C, 1'b0);
    send_line(8, 8'h11, 8'h22, 1'b0);
    frame_end();
    check("odd_line_err", {31'd0, line_err}, 32'd1);
    check("odd_frame_err", {31'd0, frame_err}, 32'd0);
    check("f3_frame_done", fd_cnt, 32'd3);

    // err_clr clears; err_clr coincident with new bad line keeps the flag
    clear_errors();
    check("err_clr_line", {31'd0, line_err}, 32'd0);
    frame_begin();
    send_line(8, 8'h0A, 8'h5C, 1'b0);
    send_line(5, 8'h0C, 8'h33, 1'b1);
    frame_end();
    check("set_beats_clr", {31'd0, line_err}, 32'd1);
    check("f4_frame_err", {31'd0, frame_err}, 32'd0);

    // Three lines: overflow after addr 7 and bad line count
    clear_errors();
    check("err_clr_line2", {31'd0, line_err}, 32'd0);
    frame_begin();
    send_line(8, 8'h0A, 8'h5C, 1'b0);
    send_line(8, 8'h0A, 8'h5C, 1'b0);
    send_line(8, 8'h0B, 8'h66, 1'b0);
    frame_end();
    check("ovf_frame_err", {31'd0, frame_err}, 32'd1);
    check("ovf_line_err", {31'd0, line_err}, 32'd0);
    check("f5_frame_done", fd_cnt, 32'd5);

    // enable dropped mid-frame: frame completes, then IDLE
    clear_errors();
    frame_begin();
    send_line(8, 8'h01, 8'h23, 1'b0);
    enable = 1'b0;
    send_line(8, 8'h04, 8'h56, 1'b0);
    frame_end();
    check("dis_frame_done", fd_cnt, 32'd6);
    check("dis_state", {30'd0, dbg_state}, 32'd0);
    check("dis_errs", {30'd0, line_err, frame_err}, 32'd0);
    cap = 0;
    frame_begin();
    send_line(8, 8'h0A, 8'h5C, 1'b0);
    send_line(8, 8'h0A, 8'h5C, 1'b0);
    frame_end();
    check("dis_no_frame", fd_cnt, 32'd6);

    // Reset mid-line, then wait for a fresh vsync falling edge
    enable = 1'b1;
    idle(3);
    cap = 1;
    frame_begin();
    send_line(8, 8'h0A, 8'h5C, 1'b0);
    cam_href = 1'b1;
    cam_data = 8'h0A;
    tick();
    rstn = 1'b0;
    #1;
    check("mid_rst_wr_addr", {13'd0, wr_addr}, 32'd0);
    check("mid_rst_outs", {27'd0, wr_en, busy, frame_done, line_err, frame_err}, 32'd0);
    check("mid_rst_state", {30'd0, dbg_state}, 32'd0);
    tick();
    rstn = 1'b1;
    cap = 0;
    for (int i = 0; i < 7; i++) begin
      cam_data = (i % 2 == 0) ? 8'h5C : 8'h0A;
      tick();
    end
    cam_href = 1'b0;
    idle(3);
    send_line(8, 8'h0A, 8'h5C, 1'b0);
    check("post_rst_state", {30'd0, dbg_state}, 32'd1);
    cap = 1;
    frame_end();
    frame_begin();
    send_line(8, 8'h03, 8'h9F, 1'b0);
    send_line(8, 8'h03, 8'h9F, 1'b0);
    frame_end();
    check("post_rst_frame_done", fd_cnt, 32'd7);
    check("post_rst_errs", {30'd0, line_err, frame_err}, 32'd0);

    idle(10);
    check("queue_empty", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
